fetch_ctrl: RTL and testbench

//  Sequences the fetch-stage program counter for the pipelined CPU.

---
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC sequencer.
// Chooses the next PC from sequential increment, branch/jump redirect or hold.
// A redirect that arrives while a fetch is still outstanding is parked until
// the memory responds, so the request address never moves under a live request.
module fetch_ctrl #(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  INSTR_BYTES = 4,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 hazard_stall_i,
  input  logic                 branch_taken_i,
  input  logic [PC_WIDTH-1:0]  branch_target_i,
  input  logic                 jump_i,
  input  logic [PC_WIDTH-1:0]  jump_target_i,
  input  logic                 imem_ready_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic                 imem_req_o,
  output logic                 if_id_write_o,
  output logic                 if_id_flush_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  localparam logic [PC_WIDTH-1:0] INC   = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN = ~PC_WIDTH'(3);

  // DRAIN always holds a valid pending target, so the state doubles as its valid bit.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    pend_q, pend_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   redirect;
  logic [PC_WIDTH-1:0]    tgt;

  // Branch (older, EX stage) beats jump (younger, ID stage); targets word-aligned.
  assign redirect = branch_taken_i | jump_i;
  assign tgt      = (branch_taken_i ? branch_target_i : jump_target_i) & ALIGN;

  // Next-state, next-PC and handshake/latch controls.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    imem_req_o    = 1'b0;
    if_id_write_o = 1'b0;
    if_id_flush_o = 1'b0;
    case (state_q)
      IDLE: begin
        if_id_flush_o = 1'b1;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        imem_req_o = 1'b1;
        if (redirect) begin
          if_id_flush_o = 1'b1;
          if (imem_ready_i) begin
            pc_d          = tgt;
            if_id_write_o = 1'b1;
          end else begin
            pend_d  = tgt;
            state_d = DRAIN;
          end
        end else if (!hazard_stall_i && imem_ready_i) begin
          pc_d          = pc_q + INC;
          if_id_write_o = 1'b1;
        end
        // hazard stall or memory wait: PC held, no IF/ID write
      end
      DRAIN: begin
        imem_req_o = 1'b1;
        if (redirect) pend_d = tgt;
        if (imem_ready_i) begin
          // stale instruction returns: write a bubble, jump to newest target
          if_id_write_o = 1'b1;
          if_id_flush_o = 1'b1;
          pc_d          = redirect ? tgt : pend_q;
          state_d       = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!start_i) begin
      state_d = IDLE;
      pc_d    = RESET_PC;
      pend_d  = '0;
    end
  end

  // Stall counter: counts active cycles where the PC does not move, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (!start_i || state_q == IDLE) cnt_d = '0;
    else if (pc_d == pc_q && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // State, PC, pending target and counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus random traffic against a behavioural
// model of the fetch sequencer, compared on every falling clock edge.
module tb_fetch_ctrl;

  localparam int PW = 32;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0, hazard_stall_i = 1'b0, branch_taken_i = 1'b0;
  logic          jump_i = 1'b0, imem_ready_i = 1'b0;
  logic [PW-1:0] branch_target_i = '0, jump_target_i = '0;
  logic [PW-1:0] pc_o;
  logic          imem_req_o, if_id_write_o, if_id_flush_o;
  logic [CW-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .hazard_stall_i(hazard_stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i), .imem_ready_i(imem_ready_i),
    .pc_o(pc_o), .imem_req_o(imem_req_o), .if_id_write_o(if_id_write_o),
    .if_id_flush_o(if_id_flush_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Model state: running flag, PC, optional parked redirect, stall count.
  bit            m_on = 0;
  logic [PW-1:0] m_pc = '0;
  bit            m_pv = 0;
  logic [PW-1:0] m_pt = '0;
  int            m_cnt = 0;

  typedef struct {
    logic [PW-1:0] npc;
    logic [PW-1:0] pt;
    bit            on, pv, req, wr, fl;
    int            cnt;
  } step_t;

  function automatic step_t model_step();
    step_t         s;
    bit            redir;
    logic [PW-1:0] tgt;
    redir = branch_taken_i || jump_i;
    tgt   = (branch_taken_i ? branch_target_i : jump_target_i) & ~32'd3;
    s.npc = m_pc; s.pt = m_pt; s.on = m_on; s.pv = m_pv; s.cnt = m_cnt;
    s.req = 0; s.wr = 0; s.fl = 0;
    if (!m_on) begin
      s.fl = 1;
      s.on = start_i;
    end else if (m_pv) begin
      s.req = 1;
      if (redir) s.pt = tgt;
      if (imem_ready_i) begin s.wr = 1; s.fl = 1; s.npc = s.pt; s.pv = 0; end
    end else begin
      s.req = 1;
      if (redir) begin
        s.fl = 1;
        if (imem_ready_i) begin s.wr = 1; s.npc = tgt; end
        else begin s.pv = 1; s.pt = tgt; end
      end else if (!hazard_stall_i && imem_ready_i) begin
        s.wr = 1; s.npc = m_pc + 32'd4;
      end
    end
    if (m_on && s.npc == m_pc) s.cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    if (!start_i) begin s.on = 0; s.npc = '0; s.pv = 0; s.pt = '0; s.cnt = 0; end
    return s;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Advance the model on each clock, or clear it on reset.
  step_t s_upd;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_on = 0; m_pc = '0; m_pv = 0; m_pt = '0; m_cnt = 0;
    end else begin
      s_upd = model_step();
      m_on = s_upd.on; m_pc = s_upd.npc; m_pv = s_upd.pv; m_pt = s_upd.pt; m_cnt = s_upd.cnt;
    end
  end

  // Compare every DUT output against the model mid-cycle.
  step_t s_chk;
  always @(negedge clk_i) begin
    s_chk = model_step();
    chk("pc_o", pc_o, m_pc);
    chk("imem_req_o", imem_req_o, s_chk.req);
    chk("if_id_write_o", if_id_write_o, s_chk.wr);
    chk("if_id_flush_o", if_id_flush_o, s_chk.fl);
    chk("stall_cnt_o", stall_cnt_o, m_cnt[CW-1:0]);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    hazard_stall_i = 0; branch_taken_i = 0; jump_i = 0; imem_ready_i = 0;
    branch_target_i = '0; jump_target_i = '0;
  endtask

  initial begin
    repeat (2) tick();
    rst_i = 1;
    // T1: async reset in the middle of DRAIN
    start_i = 1; tick();
    branch_taken_i = 1; branch_target_i = 32'h80; tick();
    branch_taken_i = 0; tick();
    chk("t1_drain_req", imem_req_o, 1'b1);
    #1 rst_i = 0;
    #1;
    chk("t1_pc", pc_o, 32'h0);
    chk("t1_req", imem_req_o, 1'b0);
    chk("t1_cnt", stall_cnt_o, 16'h0);
    chk("t1_flush_idle", if_id_flush_o, 1'b1);
    #1 rst_i = 1;
    // T2: sequential fetch
    clr(); start_i = 0; tick();
    start_i = 1; imem_ready_i = 1; tick();
    chk("t2_pc0", pc_o, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t2_pc", pc_o, 32'(4 * k));
    end
    chk("t2_cnt", stall_cnt_o, 16'h0);
    // T3: load-use stall
    jump_i = 1; jump_target_i = 32'h100; tick();
    jump_i = 0; hazard_stall_i = 1;
    #1 chk("t3_write", if_id_write_o, 1'b0);
    tick(); tick();
    chk("t3_pc", pc_o, 32'h100);
    chk("t3_cnt", stall_cnt_o, 16'd2);
    // T4: redirect while fetch outstanding
    hazard_stall_i = 0; jump_i = 1; jump_target_i = 32'h20; tick();
    chk("t4_pc20", pc_o, 32'h20);
    jump_i = 0; imem_ready_i = 0; branch_taken_i = 1; branch_target_i = 32'h80; tick();
    branch_taken_i = 0; tick(); tick();
    chk("t4_hold", pc_o, 32'h20);
    imem_ready_i = 1;
    #1 chk("t4_flush", if_id_flush_o, 1'b1);
    tick();
    chk("t4_pc80", pc_o, 32'h80);
    // T5: branch beats jump and stall
    branch_taken_i = 1; branch_target_i = 32'h40; jump_i = 1; jump_target_i = 32'h90;
    hazard_stall_i = 1;
    #1 chk("t5_flush", if_id_flush_o, 1'b1);
    tick();
    chk("t5_pc", pc_o, 32'h40);
    // T6: wrap, alignment, counter saturation
    clr(); imem_ready_i = 1; jump_i = 1; jump_target_i = 32'hFFFF_FFFC; tick();
    jump_i = 0; tick();
    chk("t6_wrap", pc_o, 32'h0);
    jump_i = 1; jump_target_i = 32'h103; tick();
    chk("t6_align", pc_o, 32'h100);
    jump_i = 0; hazard_stall_i = 1;
    repeat (65540) tick();
    chk("t6_sat", stall_cnt_o, 16'hFFFF);
    // Random traffic
    clr();
    for (int i = 0; i < 4000; i++) begin
      rst_i           = ($urandom_range(0, 299) != 0);
      start_i         = ($urandom_range(0, 39) != 0);
      hazard_stall_i  = ($urandom_range(0, 3) == 0);
      branch_taken_i  = ($urandom_range(0, 5) == 0);
      jump_i          = ($urandom_range(0, 5) == 0);
      imem_ready_i    = ($urandom_range(0, 2) != 0);
      branch_target_i = $urandom();
      jump_target_i   = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 255));
      tick();
    end
    rst_i = 1; clr(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
